// File: rtl/dmem_pkg.sv
// Shared encodings and lane helpers for the data-memory responder.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data so every enabled lane sees the right bits.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{wdata[7:0]}};
            SZ_HALF: lanes = {2{wdata[15:0]}};
            default: lanes = wdata;
        endcase
        return lanes;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = uns ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: res = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with four byte lanes, synchronous byte-enabled write and registered read.
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    input  logic                  re_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: accepts a request, waits LATENCY cycles, commits to storage, holds the response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam logic [3:0] LAT = 4'(LATENCY);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2+1:0] addr_q;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    logic                  accept;
    logic                  commit;
    logic                  req_err;
    logic                  mem_we;
    logic                  mem_re;
    logic [31:0]           mem_rdata;

    assign accept = req_valid && req_ready;
    assign commit = (state_q == WAIT) && (cnt_q == LAT);

    assign req_err = (req_size == 2'd3)
                  || ((req_size == SZ_HALF) && req_addr[0])
                  || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                  || ((req_addr >> (DEPTH_LOG2 + 2)) != 32'h0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 4'd0;
                end
            end
            WAIT: begin
                if (cnt_q == LAT) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Erroneous requests still walk the full latency but never touch storage.
    always_comb begin
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        mem_we    = commit && we_q && !err_q;
        mem_re    = commit && !we_q && !err_q;
        rsp_err   = (state_q == RESP) && err_q;
        rsp_rdata = 32'h0;
        if ((state_q == RESP) && !we_q && !err_q) begin
            rsp_rdata = load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= req_addr[DEPTH_LOG2+1:0];
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            wdata_q <= store_lanes(req_size, req_wdata);
            err_q   <= req_err;
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk    (clk),
        .addr_i (addr_q[DEPTH_LOG2+1:2]),
        .we_i   (mem_we),
        .be_i   (byte_enable(size_q, addr_q[1:0])),
        .wdata_i(wdata_q),
        .re_i   (mem_re),
        .rdata_o(mem_rdata)
    );

endmodule
